// File: rtl/mer_calc.sv
`default_nettype none
// ============================================================================
// Module      : mer_calc
// Description : MER estimator. Restoring divider forms (sig_power<<FRAC_BITS)
//               / err_power, a Mitchell log2 approximation converts the
//               quotient to Q8.8 log2, and a constant multiply (771/256 ~
//               10*log10(2)) scales it to Q8.8 dB.
// Revision    : 1.0 - initial release
// ============================================================================
module mer_calc #(
  parameter int FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [17:0] sig_power,
  input  logic [17:0] err_power,
  output logic [15:0] mer_db,
  output logic        mer_valid,
  output logic        busy,
  output logic        div_zero
);

  localparam int QW = 18 + FRAC_BITS;   // quotient / dividend width
  localparam int PW = $clog2(QW);       // leading-one index width
  localparam int CW = $clog2(QW);       // divider step counter width
  localparam logic [CW-1:0] C_CNT_LAST = CW'(QW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_NORM  = 2'd2,
    S_SCALE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] n_q, n_d;            // dividend, shifted out MSB first
  logic [17:0]   d_q, d_d;            // divisor
  logic [17:0]   rem_q, rem_d;        // partial remainder (always < divisor)
  logic [QW-1:0] quo_q, quo_d;        // quotient under construction
  logic [CW-1:0] cnt_q, cnt_d;        // quotient bits produced so far
  logic          ez_q, ez_d;          // err_power was zero at acceptance
  logic          qz_q, qz_d;          // quotient had no leading one
  logic [15:0]   l_q, l_d;            // Q8.8 log2 of the quotient ratio
  logic [15:0]   mer_db_q, mer_db_d;
  logic          mer_valid_q, mer_valid_d;
  logic          div_zero_q, div_zero_d;

  logic [18:0]        w_rem_shift;
  logic [18:0]        w_rem_diff;
  logic               w_sub_ok;
  logic [PW-1:0]      w_p;
  logic [7:0]         w_f;
  logic [7:0]         w_pm;
  logic [15:0]        w_l;
  logic signed [26:0] w_prod;
  logic [15:0]        w_mer;

  // Divider step, Mitchell log2 and dB scaling datapath
  always_comb begin
    w_rem_shift = {rem_q, n_q[QW-1]};
    w_rem_diff  = w_rem_shift - {1'b0, d_q};
    w_sub_ok    = (w_rem_shift >= {1'b0, d_q});

    // Highest set bit wins because later iterations overwrite earlier ones
    w_p = '0;
    for (int i = 0; i < QW; i++) begin
      if (quo_q[i]) begin
        w_p = i[PW-1:0];
      end
    end
    // Eight bits directly below the leading one, zero-filled under bit 0
    w_f  = 8'({quo_q, 8'b0} >> w_p);
    // (p - FRAC_BITS)*256 + f is just the byte concatenation in 16 bits
    w_pm = 8'(w_p) - 8'(FRAC_BITS);
    w_l  = {w_pm, w_f};

    w_prod = $signed({{11{l_q[15]}}, l_q}) * 27'sd771 + 27'sd128;
    w_mer  = 16'(w_prod >>> 8);
  end

  // Next-state and register-update logic for the conversion sequence
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    d_d         = d_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    ez_d        = ez_q;
    qz_d        = qz_q;
    l_d         = l_q;
    mer_db_d    = mer_db_q;
    mer_valid_d = 1'b0;
    div_zero_d  = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (start && clk_en) begin
          n_d     = {sig_power, {FRAC_BITS{1'b0}}};
          d_d     = err_power;
          ez_d    = (err_power == 18'd0);
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        n_d   = n_q << 1;
        rem_d = w_sub_ok ? 18'(w_rem_diff) : 18'(w_rem_shift);
        quo_d = {quo_q[QW-2:0], w_sub_ok};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_CNT_LAST) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        qz_d    = (quo_q == '0);
        l_d     = w_l;
        state_d = S_SCALE;
      end
      S_SCALE: begin
        mer_valid_d = 1'b1;
        if (ez_q) begin
          mer_db_d   = 16'h7FFF;
          div_zero_d = 1'b1;
        end else if (qz_q) begin
          mer_db_d   = 16'h8000;
          div_zero_d = 1'b0;
        end else begin
          mer_db_d   = w_mer;
          div_zero_d = 1'b0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      d_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      ez_q        <= 1'b0;
      qz_q        <= 1'b0;
      l_q         <= '0;
      mer_db_q    <= '0;
      mer_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      d_q         <= d_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      ez_q        <= ez_d;
      qz_q        <= qz_d;
      l_q         <= l_d;
      mer_db_q    <= mer_db_d;
      mer_valid_q <= mer_valid_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign mer_db    = mer_db_q;
  assign mer_valid = mer_valid_q;
  assign div_zero  = div_zero_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mer_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_mer_calc
// Description : Self-checking bench for mer_calc: directed corner cases plus
//               randomized operands against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mer_calc;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [17:0] sig_power;
  logic [17:0] err_power;
  logic [15:0] mer_db;
  logic        mer_valid;
  logic        busy;
  logic        div_zero;

  int n_checks;
  int n_errors;

  mer_calc #(.FRAC_BITS(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .start     (start),
    .sig_power (sig_power),
    .err_power (err_power),
    .mer_db    (mer_db),
    .mer_valid (mer_valid),
    .busy      (busy),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer ratio, log2 by repeated halving, dB by floor of
  // (L*771 + 128)/256.
  task automatic ref_mer(input logic [17:0] s, input logic [17:0] e,
                         output logic [15:0] m, output logic dz);
    longint q, t, f, l, prod;
    int p;
    if (e == 18'd0) begin
      m  = 16'h7FFF;
      dz = 1'b1;
    end else begin
      dz = 1'b0;
      q  = (longint'(s) * 256) / longint'(e);
      if (q == 0) begin
        m = 16'h8000;
      end else begin
        p = 0;
        t = q;
        while (t > 1) begin
          t = t / 2;
          p++;
        end
        f    = ((q * 256) / (longint'(1) << p)) % 256;
        l    = longint'(p - 8) * 256 + f;
        prod = l * 771 + 128;
        m    = 16'(prod >>> 8);
      end
    end
  endtask

  // One conversion: accept, optionally disturb start while busy, then check
  // latency, busy window, result and hold behaviour.
  // noise: 0 quiet, 1 random start/clk_en while busy, 2 start at T+5 and T+16
  task automatic run_op(input logic [17:0] s, input logic [17:0] e, input int noise,
                        input string tag);
    logic [15:0] exp_m;
    logic        exp_dz;
    int          vcnt;
    int          vk;
    ref_mer(s, e, exp_m, exp_dz);
    @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    sig_power = s;
    err_power = e;
    start     = 1'b1;
    clk_en    = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    clk_en    = 1'($urandom_range(0, 1));
    sig_power = 18'($urandom);
    err_power = 18'($urandom);
    vcnt = 0;
    vk   = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (mer_valid) begin
        vcnt++;
        if (vk == 0) vk = k;
        if (k == 29) begin
          chk({tag, "_mer"}, 32'(mer_db), 32'(exp_m));
          chk({tag, "_dz"}, 32'(div_zero), 32'(exp_dz));
        end
      end
      if (k == 1)  chk({tag, "_busy1"}, 32'(busy), 32'd1);
      if (k == 28) chk({tag, "_busy28"}, 32'(busy), 32'd1);
      if (k == 29) chk({tag, "_busy29"}, 32'(busy), 32'd0);
      start  = 1'b0;
      clk_en = 1'b1;
      if (noise == 1 && k < 26) begin
        start  = 1'($urandom_range(0, 1));
        clk_en = 1'($urandom_range(0, 1));
      end else if (noise == 2 && (k == 5 || k == 16)) begin
        start = 1'b1;
      end
    end
    chk({tag, "_vcnt"}, 32'(vcnt), 32'd1);
    chk({tag, "_lat"}, 32'(vk), 32'd29);
    chk({tag, "_hold"}, 32'(mer_db), 32'(exp_m));
    chk({tag, "_holddz"}, 32'(div_zero), 32'(exp_dz));
  endtask

  initial begin
    int          vcnt;
    logic [17:0] rs;
    logic [17:0] re;
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    clk_en    = 1'b0;
    start     = 1'b0;
    sig_power = '0;
    err_power = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mer", 32'(mer_db), 32'd0);
    chk("rst_valid", 32'(mer_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);

    // Directed cases with hand-derived expectations
    run_op(18'h10000, 18'h00100, 0, "t1");
    chk("t1_exact", 32'(mer_db), 32'd6168);
    run_op(18'h04000, 18'h04000, 0, "t2");
    chk("t2_exact", 32'(mer_db), 32'd0);
    run_op(18'h03000, 18'h01000, 0, "t3");
    chk("t3_exact", 32'(mer_db), 32'd1157);
    run_op(18'h10000, 18'h00000, 0, "t4a");
    chk("t4a_exact", 32'(mer_db), 32'h7FFF);
    run_op(18'h00000, 18'h00100, 0, "t4b");
    chk("t4b_exact", 32'(mer_db), 32'h8000);
    run_op(18'h00000, 18'h00000, 0, "t4c");
    run_op(18'h10000, 18'h00100, 2, "t5");
    run_op(18'h3FFFF, 18'h00001, 0, "tmax");
    run_op(18'h00001, 18'h3FFFF, 0, "tmin");
    run_op(18'h00100, 18'h3FFFF, 0, "tneg");

    // start with clk_en low is never accepted
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start  = 1'($urandom_range(0, 1));
      clk_en = 1'b0;
      if (mer_valid) vcnt++;
      if (busy) vcnt++;
    end
    @(negedge clk);
    start = 1'b0;
    if (mer_valid) vcnt++;
    if (busy) vcnt++;
    chk("noen_ignored", 32'(vcnt), 32'd0);

    // Reset mid-DIV abandons the conversion
    @(negedge clk);
    sig_power = 18'h10000;
    err_power = 18'h00100;
    start     = 1'b1;
    clk_en    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_mer", 32'(mer_db), 32'd0);
    chk("rmid_valid", 32'(mer_valid), 32'd0);
    chk("rmid_dz", 32'(div_zero), 32'd0);
    vcnt = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (mer_valid) vcnt++;
    end
    chk("rmid_nopulse", 32'(vcnt), 32'd0);
    run_op(18'h10000, 18'h00100, 0, "t6");

    // Randomized operands, occasionally forcing zero or tiny values
    for (int n = 0; n < 25; n++) begin
      rs = 18'($urandom);
      re = 18'($urandom);
      case ($urandom_range(0, 7))
        0: re = 18'd0;
        1: rs = 18'd0;
        2: re = 18'($urandom_range(1, 15));
        3: rs = 18'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rs, re, 1, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so the run always ends on its own
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
